// File: rtl/current_sample_ctrl.sv
// Periodic two-phase current sampler: triggers both sensor PHYs, collects completions,
// reconstructs ic = -(ia+ib) with saturation, and tracks consecutive bad samples into a sticky fault.
module current_sample_ctrl #(
  parameter int DATA_WIDTH        = 16,
  parameter int SAMPLE_PERIOD_CNT = 5000,
  parameter int TIMEOUT_CNT       = 2000,
  parameter int ERR_LIMIT         = 3
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic                         sample_enable_in,
  input  logic                         fault_clr_in,
  output logic                         detect_enable_out,
  input  logic signed [DATA_WIDTH-1:0] ia_in,
  input  logic signed [DATA_WIDTH-1:0] ib_in,
  input  logic                         a_done_in,
  input  logic                         b_done_in,
  input  logic                         a_err_in,
  input  logic                         b_err_in,
  output logic signed [DATA_WIDTH-1:0] ia_out,
  output logic signed [DATA_WIDTH-1:0] ib_out,
  output logic signed [DATA_WIDTH-1:0] ic_out,
  output logic                         current_valid_out,
  output logic                         fault_out,
  output logic [3:0]                   fault_code_out,
  output logic                         overrun_out
);

  localparam int PW = (SAMPLE_PERIOD_CNT > 1) ? $clog2(SAMPLE_PERIOD_CNT) : 1;
  localparam int TW = $clog2(TIMEOUT_CNT + 1);
  localparam logic signed [DATA_WIDTH+1:0] IC_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH+1:0] IC_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, TRIGGER, WAIT, CALC} state_t;

  state_t          state;
  logic [PW-1:0]   period_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [3:0]      err_cnt;
  logic            a_got, b_got, a_bad, b_bad, timeout;
  logic            tick;
  logic            a_got_n, b_got_n, a_bad_n, b_bad_n, bad;
  logic [3:0]      err_next;

  logic signed [DATA_WIDTH:0]   sum;
  logic signed [DATA_WIDTH+1:0] neg;
  logic signed [DATA_WIDTH-1:0] ic_sat;

  // Free-running sample period; tick is qualified so a disabled counter never fires.
  always_ff @(posedge sys_clk) begin
    if (reset || !sample_enable_in)
      period_cnt <= '0;
    else if (period_cnt == PW'(SAMPLE_PERIOD_CNT - 1))
      period_cnt <= '0;
    else
      period_cnt <= period_cnt + PW'(1);
  end

  assign tick = sample_enable_in && (period_cnt == PW'(SAMPLE_PERIOD_CNT - 1));

  // Completion flags including pulses arriving this cycle.
  assign a_got_n = a_got | a_done_in | a_err_in;
  assign b_got_n = b_got | b_done_in | b_err_in;
  assign a_bad_n = a_bad | a_err_in;
  assign b_bad_n = b_bad | b_err_in;
  assign bad     = a_bad | b_bad | timeout;
  assign err_next = (err_cnt == 4'hF) ? 4'hF : err_cnt + 4'd1;

  // Widen before sum and negate so -(min+min) cannot wrap before the clamp.
  always_comb begin
    sum    = {ia_in[DATA_WIDTH-1], ia_in} + {ib_in[DATA_WIDTH-1], ib_in};
    neg    = -{sum[DATA_WIDTH], sum};
    ic_sat = neg[DATA_WIDTH-1:0];
    if (neg > IC_MAX)      ic_sat = IC_MAX[DATA_WIDTH-1:0];
    else if (neg < IC_MIN) ic_sat = IC_MIN[DATA_WIDTH-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state             <= IDLE;
      detect_enable_out <= 1'b0;
      current_valid_out <= 1'b0;
      ia_out            <= '0;
      ib_out            <= '0;
      ic_out            <= '0;
      fault_out         <= 1'b0;
      fault_code_out    <= 4'h0;
      overrun_out       <= 1'b0;
      err_cnt           <= 4'h0;
      tmo_cnt           <= '0;
      a_got             <= 1'b0;
      b_got             <= 1'b0;
      a_bad             <= 1'b0;
      b_bad             <= 1'b0;
      timeout           <= 1'b0;
    end else begin
      detect_enable_out <= 1'b0;
      current_valid_out <= 1'b0;

      if (fault_clr_in) begin
        fault_out      <= 1'b0;
        fault_code_out <= 4'h0;
        overrun_out    <= 1'b0;
        err_cnt        <= 4'h0;
      end

      if (tick && state != IDLE)
        overrun_out <= 1'b1;

      case (state)
        IDLE: begin
          if (tick && !fault_out) begin
            detect_enable_out <= 1'b1;
            state             <= TRIGGER;
          end
        end
        TRIGGER: begin
          a_got   <= 1'b0;
          b_got   <= 1'b0;
          a_bad   <= 1'b0;
          b_bad   <= 1'b0;
          timeout <= 1'b0;
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          a_got   <= a_got_n;
          b_got   <= b_got_n;
          a_bad   <= a_bad_n;
          b_bad   <= b_bad_n;
          tmo_cnt <= tmo_cnt + TW'(1);
          if (a_got_n && b_got_n) begin
            state <= CALC;
          end else if (tmo_cnt == TW'(TIMEOUT_CNT - 1)) begin
            timeout <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (!bad) begin
            ia_out            <= ia_in;
            ib_out            <= ib_in;
            ic_out            <= ic_sat;
            current_valid_out <= 1'b1;
            err_cnt           <= 4'h0;
          end else begin
            err_cnt <= err_next;
            // A fault set here overrides a clear in the same cycle.
            if (err_next >= 4'(ERR_LIMIT)) begin
              fault_out      <= 1'b1;
              fault_code_out <= {overrun_out, timeout, b_bad, a_bad};
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_current_sample_ctrl.sv
// Bench for current_sample_ctrl: PHY responder plus sample-level reference model feeding a
// scoreboard queue; a separate monitor checks every valid triple against it.
module tb_current_sample_ctrl;
  localparam int DW   = 16;
  localparam int PER  = 40;
  localparam int TO   = 50;
  localparam int LIM  = 3;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  logic sys_clk = 0, reset = 1, sample_enable_in = 0, fault_clr_in = 0;
  logic a_done_in = 0, b_done_in = 0, a_err_in = 0, b_err_in = 0;
  logic signed [DW-1:0] ia_in = 0, ib_in = 0;
  logic detect_enable_out, current_valid_out, fault_out, overrun_out;
  logic signed [DW-1:0] ia_out, ib_out, ic_out;
  logic [3:0] fault_code_out;

  current_sample_ctrl #(.DATA_WIDTH(DW), .SAMPLE_PERIOD_CNT(PER), .TIMEOUT_CNT(TO), .ERR_LIMIT(LIM)) dut (
    .sys_clk(sys_clk), .reset(reset), .sample_enable_in(sample_enable_in), .fault_clr_in(fault_clr_in),
    .detect_enable_out(detect_enable_out), .ia_in(ia_in), .ib_in(ib_in),
    .a_done_in(a_done_in), .b_done_in(b_done_in), .a_err_in(a_err_in), .b_err_in(b_err_in),
    .ia_out(ia_out), .ib_out(ib_out), .ic_out(ic_out), .current_valid_out(current_valid_out),
    .fault_out(fault_out), .fault_code_out(fault_code_out), .overrun_out(overrun_out));

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {int cyc; int ia; int ib; int ic;} exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;
  int m_ecnt = 0, m_ia = 0, m_ib = 0, m_ic = 0, m_code = 0;
  bit m_fault = 0, m_ovr = 0;
  int prev_e = -1, prev_calc = -1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sat_ic(input int a, input int b);
    int s;
    s = -(a + b);
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
  endfunction

  // Scoreboard consumer
  always @(negedge sys_clk) begin
    exp_t x;
    if (!reset && current_valid_out) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        x = q.pop_front();
        chk("valid_cycle", cyc, x.cyc);
        chk("ia_out", int'(ia_out), x.ia);
        chk("ib_out", int'(ib_out), x.ib);
        chk("ic_out", int'(ic_out), x.ic);
      end
    end
  end

  task automatic wait_detect(output int e, output bit ok);
    ok = 0; e = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (detect_enable_out) begin e = cyc; ok = 1; return; end
    end
  endtask

  task automatic clear_fault();
    bit seen;
    seen = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge sys_clk);
      if (detect_enable_out) seen = 1;
    end
    chk("no_detect_while_fault", seen, 0);
    @(posedge sys_clk); #1 fault_clr_in = 1;
    @(posedge sys_clk); #1 fault_clr_in = 0;
    @(negedge sys_clk);
    m_fault = 0; m_code = 0; m_ovr = 0; m_ecnt = 0; prev_calc = -1;
    chk("fault_after_clr", fault_out, 0);
    chk("code_after_clr", int'(fault_code_out), 0);
    chk("overrun_after_clr", overrun_out, 0);
  endtask

  // da/db: completion delay in cycles after the enable pulse; 0 means never responds.
  task automatic run_sample(input int da, input int db, input bit ae, input bit be, input int va, input int vb);
    int e, m, L, t;
    bit ok, to, abad, bbad, ovr_pre;
    exp_t x;
    wait_detect(e, ok);
    chk("detect_seen", ok, 1);
    if (!ok) return;
    if (prev_calc >= 0) begin
      t = prev_e - 1 + PER;
      while (t < prev_calc + 1) t += PER;
      chk("detect_cycle", e, t + 1);
    end
    ia_in = DW'(va); ib_in = DW'(vb);
    to = (da == 0) || (db == 0);
    m  = (da > db) ? da : db;
    L  = to ? TO : m;
    abad = ae && da != 0;
    bbad = be && db != 0;
    // Ticks landing in the busy window E..E+L are visible to the fault code.
    ovr_pre = m_ovr;
    for (int c = e; c <= e + L; c++) if ((c - (e - 1)) % PER == 0) ovr_pre = 1;
    if (abad || bbad || to) begin
      m_ecnt = (m_ecnt >= 15) ? 15 : m_ecnt + 1;
      if (m_ecnt >= LIM) begin
        m_fault = 1;
        m_code  = {28'd0, ovr_pre, to, bbad, abad};
      end
    end else begin
      m_ecnt = 0;
      m_ia = va; m_ib = vb; m_ic = sat_ic(va, vb);
      x.cyc = e + L + 2; x.ia = m_ia; x.ib = m_ib; x.ic = m_ic;
      q.push_back(x);
    end
    m_ovr = ovr_pre || (((e + L + 1) - (e - 1)) % PER == 0);
    for (int k = 1; k <= L; k++) begin
      @(posedge sys_clk); #1;
      a_done_in = (k == da) && !ae; a_err_in = (k == da) && ae;
      b_done_in = (k == db) && !be; b_err_in = (k == db) && be;
    end
    @(posedge sys_clk); #1;
    a_done_in = 0; a_err_in = 0; b_done_in = 0; b_err_in = 0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("fault_out", fault_out, m_fault);
    chk("fault_code", int'(fault_code_out), m_code);
    chk("overrun_out", overrun_out, m_ovr);
    chk("ia_hold", int'(ia_out), m_ia);
    chk("ib_hold", int'(ib_out), m_ib);
    chk("ic_hold", int'(ic_out), m_ic);
    prev_e = e; prev_calc = e + L + 1;
    if (m_fault) clear_fault();
  endtask

  initial begin
    int e, va, vb, da, db;
    bit ok;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_detect", detect_enable_out, 0);
    chk("rst_valid", current_valid_out, 0);
    chk("rst_ia", int'(ia_out), 0);
    chk("rst_ic", int'(ic_out), 0);
    chk("rst_fault", fault_out, 0);
    chk("rst_code", int'(fault_code_out), 0);
    chk("rst_overrun", overrun_out, 0);
    #1 reset = 0; sample_enable_in = 1;

    run_sample(30, 30, 0, 0, 1000, -300);
    run_sample(10, 34, 0, 0, -4096, -4096);
    run_sample(5, 5, 0, 0, 1234, 567);
    run_sample(7, 9, 0, 0, -32768, -32768);
    run_sample(3, 4, 0, 0, 32767, 32767);
    // err, err, good, err, err (no fault), err (fault 0010)
    run_sample(10, 12, 0, 1, 11, 22);
    run_sample(10, 12, 0, 1, 11, 22);
    run_sample(8, 8, 0, 0, -5, 6);
    run_sample(10, 12, 0, 1, 11, 22);
    run_sample(10, 12, 0, 1, 11, 22);
    run_sample(10, 12, 0, 1, 11, 22);
    // B silent: timeouts with overrun, third one faults with 1100
    run_sample(10, 0, 0, 0, 1, 2);
    run_sample(10, 0, 0, 0, 1, 2);
    run_sample(10, 0, 0, 0, 1, 2);

    for (int i = 0; i < 30; i++) begin
      va = int'($urandom_range(0, 65535)) - 32768;
      vb = int'($urandom_range(0, 65535)) - 32768;
      da = int'($urandom_range(1, 35));
      db = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 35));
      run_sample(da, db, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, va, vb);
    end

    // Reset in the middle of WAIT, then late completions must be ignored
    wait_detect(e, ok);
    chk("detect_before_reset", ok, 1);
    repeat (10) @(posedge sys_clk);
    #1 reset = 1;
    @(posedge sys_clk); #1 reset = 0;
    @(negedge sys_clk);
    chk("midrst_ia", int'(ia_out), 0);
    chk("midrst_ib", int'(ib_out), 0);
    chk("midrst_ic", int'(ic_out), 0);
    chk("midrst_fault", fault_out, 0);
    chk("midrst_overrun", overrun_out, 0);
    chk("midrst_detect", detect_enable_out, 0);
    @(posedge sys_clk); #1 a_done_in = 1; b_done_in = 1;
    @(posedge sys_clk); #1 a_done_in = 0; b_done_in = 0;
    m_ia = 0; m_ib = 0; m_ic = 0; m_ecnt = 0; m_fault = 0; m_code = 0; m_ovr = 0; prev_calc = -1;
    run_sample(6, 9, 0, 0, 200, 300);

    repeat (5) @(negedge sys_clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
